shared_reg_arbiter: RTL

Round-robin arbiter and write sequencer for one shared WIDTH-bit register, built from a bank of D flip-flops with synchronous clear. Up to NUM_REQ requesters compete for write access. The block grants one requester at a time, captures that requester's data into the register and returns a one-cycle acknowledge. It sits between several producer blocks and a single shared status/data register.

---
 rtl/shared_reg_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// Define ARB_FIXED_PRIO_EN to make the lowest-index requester always win.
module shared_reg_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*WIDTH-1:0] i_wdata,
    input  logic                     i_clr,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic [WIDTH-1:0]         o_q,
    output logic [IDX_W-1:0]         o_owner,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] win_nxt;
    logic             any_req;
    logic [WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign wdata_arr[k] = i_wdata[k*WIDTH +: WIDTH];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

`ifdef ARB_FIXED_PRIO_EN
    // Scan downward so the lowest set bit is the last to be written.
    always_comb begin
        win_nxt = '0;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                win_nxt = IDX_W'(i);
                any_req = 1'b1;
            end
        end
    end
`else
    localparam logic [IDX_W:0]   NREQ = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;

    // Explicit wrap: NUM_REQ need not be a power of two.
    always_comb begin
        win_nxt = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any_req && i_req[cand[IDX_W-1:0]]) begin
                win_nxt = cand[IDX_W-1:0];
                any_req = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            win     <= '0;
            o_gnt   <= '0;
            o_ack   <= '0;
            o_owner <= '0;
            o_busy  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else begin
            o_gnt <= '0;
            o_ack <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        win    <= win_nxt;
                        o_gnt  <= onehot(win_nxt);
                        o_busy <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    o_ack   <= onehot(win);
                    o_owner <= win;
                    state   <= DONE;
                end
                DONE: begin
`ifndef ARB_FIXED_PRIO_EN
                    ptr    <= (win == LAST) ? '0 : win + 1'b1;
`endif
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Clear beats the capture when both land on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_clr) begin
            o_q <= '0;
        end else if (state == GRANT) begin
            o_q <= wdata_arr[win];
        end
    end

endmodule
